// File: rtl/soc_reset_sequencer.sv
// Fabric reset sequencer for mor1kx_soc: holds the SoC in reset after power-up/HPS reset and turns
// ISSP request levels into fixed-width cold/warm/debug pulses. Optional button debounce: SOC_RSTSEQ_DEBOUNCE_EN.
module soc_reset_sequencer #(
    parameter int HOLD_CYCLES     = 64,
    parameter int COLD_EXT        = 6,
    parameter int WARM_EXT        = 2,
    parameter int DEBUG_EXT       = 32,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       hps_rstn_i,
    input  logic [2:0] req_i,
    input  logic       btn_ni,
    output logic       soc_rstn_o,
    output logic       cold_req_o,
    output logic       warm_req_o,
    output logic       debug_req_o,
    output logic [1:0] state_o
);

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CNT_MAX = max_of(max_of(HOLD_CYCLES, COLD_EXT), max_of(WARM_EXT, DEBUG_EXT));
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] COLD_LOAD  = CNT_W'(COLD_EXT);
    localparam logic [CNT_W-1:0] WARM_LOAD  = CNT_W'(WARM_EXT);
    localparam logic [CNT_W-1:0] DEBUG_LOAD = CNT_W'(DEBUG_EXT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PULSE = 2'd2
    } state_e;

    logic       hps_meta_q, hps_sync_q;
    logic [2:0] req_meta_q, req_sync_q, req_prev_q;
    logic [2:0] req_rise;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hps_meta_q <= 1'b0;
            hps_sync_q <= 1'b0;
            req_meta_q <= '0;
            req_sync_q <= '0;
            req_prev_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so each flop captures its predecessor's pre-edge value.
            hps_meta_q <= hps_rstn_i;
            hps_sync_q <= hps_meta_q;
            req_meta_q <= req_i;
            req_sync_q <= req_meta_q;
            req_prev_q <= req_sync_q;
        end
    end

    assign req_rise = req_sync_q & ~req_prev_q;

    logic btn_evt;

`ifdef SOC_RSTSEQ_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_FULL = DB_W'(DEBOUNCE_CYCLES);

    logic            btn_meta_q, btn_sync_q, btn_prev_q;
    logic [DB_W-1:0] stable_q, stable_d;
    logic            db_level_q, db_level_d, db_prev_q;

    // stable_q is the length of the current run of identical samples, saturating at DEBOUNCE_CYCLES.
    always_comb begin
        stable_d   = stable_q;
        db_level_d = db_level_q;
        if (stable_q == '0 || btn_sync_q != btn_prev_q) begin
            stable_d = DB_W'(1);
        end else if (stable_q != DB_FULL) begin
            stable_d = stable_q + DB_W'(1);
        end
        if (stable_d == DB_FULL) begin
            db_level_d = btn_sync_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
            stable_q   <= '0;
            db_level_q <= 1'b1;
            db_prev_q  <= 1'b1;
        end else begin
            btn_meta_q <= btn_ni;
            btn_sync_q <= btn_meta_q;
            if (!hps_sync_q) begin
                btn_prev_q <= 1'b0;
                stable_q   <= '0;
                db_level_q <= 1'b1;
                db_prev_q  <= 1'b1;
            end else begin
                btn_prev_q <= btn_sync_q;
                stable_q   <= stable_d;
                db_level_q <= db_level_d;
                db_prev_q  <= db_level_q;
            end
        end
    end

    assign btn_evt = db_prev_q & ~db_level_q;
`else
    logic unused_btn;
    assign unused_btn = btn_ni ^ (DEBOUNCE_CYCLES > 1);
    assign btn_evt    = 1'b0;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             soc_rstn_q, soc_rstn_d;
    logic             cold_q, cold_d;
    logic             warm_q, warm_d;
    logic             debug_q, debug_d;
    logic             cold_evt, warm_evt, debug_evt;

    assign cold_evt  = req_rise[0];
    assign warm_evt  = req_rise[1] | btn_evt;
    assign debug_evt = req_rise[2];

    always_comb begin
        // NOTE: every next-state signal defaults to its held value so no path can infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        soc_rstn_d = soc_rstn_q;
        cold_d     = cold_q;
        warm_d     = warm_q;
        debug_d    = debug_q;

        if (!hps_sync_q) begin
            state_d    = ST_HOLD;
            cnt_d      = '0;
            soc_rstn_d = 1'b0;
            cold_d     = 1'b0;
            warm_d     = 1'b0;
            debug_d    = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD, ST_RUN: begin
                    if (cold_evt) begin
                        state_d    = ST_PULSE;
                        cnt_d      = COLD_LOAD;
                        cold_d     = 1'b1;
                        soc_rstn_d = 1'b0;
                    end else if (warm_evt) begin
                        state_d    = ST_PULSE;
                        cnt_d      = WARM_LOAD;
                        warm_d     = 1'b1;
                        soc_rstn_d = 1'b0;
                    end else if (debug_evt) begin
                        // Debug leaves the SoC reset level untouched.
                        state_d = ST_PULSE;
                        cnt_d   = DEBUG_LOAD;
                        debug_d = 1'b1;
                    end else if (state_q == ST_HOLD) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d    = ST_RUN;
                            cnt_d      = '0;
                            soc_rstn_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                ST_PULSE: begin
                    if (cnt_q <= CNT_ONE) begin
                        cnt_d   = '0;
                        cold_d  = 1'b0;
                        warm_d  = 1'b0;
                        debug_d = 1'b0;
                        if (debug_q && soc_rstn_q) begin
                            state_d = ST_RUN;
                        end else begin
                            state_d    = ST_HOLD;
                            soc_rstn_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d    = ST_HOLD;
                    cnt_d      = '0;
                    soc_rstn_d = 1'b0;
                    cold_d     = 1'b0;
                    warm_d     = 1'b0;
                    debug_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_HOLD;
            cnt_q      <= '0;
            soc_rstn_q <= 1'b0;
            cold_q     <= 1'b0;
            warm_q     <= 1'b0;
            debug_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            soc_rstn_q <= soc_rstn_d;
            cold_q     <= cold_d;
            warm_q     <= warm_d;
            debug_q    <= debug_d;
        end
    end

    assign soc_rstn_o  = soc_rstn_q;
    assign cold_req_o  = cold_q;
    assign warm_req_o  = warm_q;
    assign debug_req_o = debug_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Self-checking bench for soc_reset_sequencer: a cycle model built from the behavioural rules
// (delay lines, hold/pulse countdowns) compared every cycle, plus hand-computed literal checks.
module tb_soc_reset_sequencer;

    localparam int HOLD = 8;
    localparam int COLD = 6;
    localparam int WARM = 2;
    localparam int DBG  = 32;
    localparam int DEB  = 4;

    localparam int K_NONE = 0;
    localparam int K_COLD = 1;
    localparam int K_WARM = 2;
    localparam int K_DBG  = 3;

    logic       clk = 1'b0;
    logic       rstn;
    logic       hps;
    logic [2:0] req;
    logic       btn;
    logic       soc_rstn, cold, warm, debug;
    logic [1:0] state;

    soc_reset_sequencer #(
        .HOLD_CYCLES    (HOLD),
        .COLD_EXT       (COLD),
        .WARM_EXT       (WARM),
        .DEBUG_EXT      (DBG),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .hps_rstn_i (hps),
        .req_i      (req),
        .btn_ni     (btn),
        .soc_rstn_o (soc_rstn),
        .cold_req_o (cold),
        .warm_req_o (warm),
        .debug_req_o(debug),
        .state_o    (state)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic       hps_pipe [2];
    logic [2:0] req_pipe [2];
    logic       btn_pipe [2];
    logic [2:0] req_last;
    bit         m_soc;
    int         m_kind;
    int         m_left;
    int         m_hold;
    bit         btn_hist [$];
    bit         m_level;
    bit         m_btn_evt;
    bit         model_on = 1'b0;

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            hps_pipe[i] = 1'b0;
            req_pipe[i] = '0;
            btn_pipe[i] = 1'b0;
        end
        req_last  = '0;
        m_soc     = 1'b0;
        m_kind    = K_NONE;
        m_left    = 0;
        m_hold    = 0;
        btn_hist.delete();
        m_level   = 1'b1;
        m_btn_evt = 1'b0;
    endtask

    function automatic int m_state();
        if (m_kind != K_NONE) return 2;
        return m_soc ? 1 : 0;
    endfunction

    task automatic model_step();
        logic       hps_s;
        logic [2:0] req_s;
        logic [2:0] rise;
        bit         cold_e, warm_e, dbg_e;
        if (!rstn) begin
            model_reset();
            return;
        end
        hps_s = hps_pipe[1];
        req_s = req_pipe[1];
`ifdef SOC_RSTSEQ_DEBOUNCE_EN
        begin
            logic btn_s;
            bit   all_eq;
            bit   new_level;
            btn_s = btn_pipe[1];
            warm_e = m_btn_evt;
            if (!hps_s) begin
                btn_hist.delete();
                m_level   = 1'b1;
                m_btn_evt = 1'b0;
            end else begin
                btn_hist.push_back(btn_s);
                if (btn_hist.size() > DEB) void'(btn_hist.pop_front());
                all_eq = (btn_hist.size() == DEB);
                foreach (btn_hist[i]) if (btn_hist[i] != btn_s) all_eq = 1'b0;
                new_level = all_eq ? btn_s : m_level;
                m_btn_evt = m_level && !new_level;
                m_level   = new_level;
            end
        end
`else
        warm_e = 1'b0;
`endif
        hps_pipe[1] = hps_pipe[0];
        hps_pipe[0] = hps;
        req_pipe[1] = req_pipe[0];
        req_pipe[0] = req;
        btn_pipe[1] = btn_pipe[0];
        btn_pipe[0] = btn;

        rise     = req_s & ~req_last;
        req_last = req_s;
        cold_e   = rise[0];
        warm_e   = warm_e || rise[1];
        dbg_e    = rise[2];

        if (!hps_s) begin
            m_kind = K_NONE;
            m_left = 0;
            m_soc  = 1'b0;
            m_hold = 0;
        end else if (m_kind != K_NONE) begin
            m_left--;
            if (m_left == 0) begin
                if (!(m_kind == K_DBG && m_soc)) begin
                    m_soc  = 1'b0;
                    m_hold = 0;
                end
                m_kind = K_NONE;
            end
        end else if (cold_e) begin
            m_kind = K_COLD;
            m_left = COLD;
            m_soc  = 1'b0;
        end else if (warm_e) begin
            m_kind = K_WARM;
            m_left = WARM;
            m_soc  = 1'b0;
        end else if (dbg_e) begin
            m_kind = K_DBG;
            m_left = DBG;
        end else if (!m_soc) begin
            m_hold++;
            if (m_hold == HOLD) m_soc = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            check("cyc_soc_rstn", soc_rstn, m_soc);
            check("cyc_cold", cold, m_kind == K_COLD);
            check("cyc_warm", warm, m_kind == K_WARM);
            check("cyc_debug", debug, m_kind == K_DBG);
            check("cyc_state", state, m_state());
        end
    end

    // ---------------- stimulus ----------------
    int n_cold, n_warm, n_dbg, n_soc_lo;

    task automatic clear_counts();
        n_cold   = 0;
        n_warm   = 0;
        n_dbg    = 0;
        n_soc_lo = 0;
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (cold) n_cold++;
            if (warm) n_warm++;
            if (debug) n_dbg++;
            if (!soc_rstn) n_soc_lo++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rstn = 1'b0;
        hps  = 1'b1;
        req  = '0;
        btn  = 1'b1;
        model_reset();
        clear_counts();
        model_on = 1'b1;
        tick(3);
        check("rst_soc_rstn", soc_rstn, 0);
        check("rst_reqs", {cold, warm, debug}, 0);
        check("rst_state", state, 0);

        // Power-up hold: release at edge 2 + HOLD = 10.
        rstn = 1'b1;
        clear_counts();
        tick(9);
        check("soc_before_edge10", soc_rstn, 0);
        tick(1);
        check("soc_at_edge10", soc_rstn, 1);
        check("state_run", state, 1);
        check("no_req_at_powerup", n_cold + n_warm + n_dbg, 0);
        tick(4);

        // Cold level held high: one 6-cycle pulse, SoC low 6 + 8 cycles.
        req = 3'b001;
        clear_counts();
        tick(2);
        check("cold_latency_2", cold, 0);
        tick(1);
        check("cold_latency_3", cold, 1);
        check("cold_soc_low", soc_rstn, 0);
        tick(40);
        check("cold_width", n_cold, COLD);
        check("cold_soc_low_cycles", n_soc_lo, COLD + HOLD);
        check("cold_soc_back", soc_rstn, 1);
        req = '0;
        tick(5);

        // Warm and debug together: warm wins, debug dropped.
        req = 3'b110;
        clear_counts();
        tick(3);
        check("prio_warm_on", warm, 1);
        check("prio_debug_off", debug, 0);
        tick(20);
        check("prio_warm_width", n_warm, WARM);
        check("prio_debug_none", n_dbg, 0);
        req = '0;
        tick(3);

        // Debug alone: 32 cycles, SoC stays out of reset.
        req = 3'b100;
        clear_counts();
        tick(1);
        req = '0;
        tick(2);
        check("debug_on", debug, 1);
        tick(40);
        check("debug_width", n_dbg, DBG);
        check("debug_soc_high", n_soc_lo, 0);
        check("debug_back_run", state, 1);

        // HPS reset during a debug pulse truncates it.
        req = 3'b100;
        tick(1);
        req = '0;
        tick(2);
        check("debug2_on", debug, 1);
        tick(5);
        hps = 1'b0;
        tick(3);
        check("hps_drop_debug", debug, 0);
        check("hps_drop_state", state, 0);
        check("hps_drop_soc", soc_rstn, 0);
        hps = 1'b1;
        k = 0;
        while (!soc_rstn && k < 50) begin
            tick(1);
            k++;
        end
        check("hps_return_latency", k, 2 + HOLD);

        // Warm edge during a cold pulse is ignored.
        tick(3);
        req = 3'b001;
        clear_counts();
        tick(1);
        req = '0;
        tick(2);
        check("cold2_on", cold, 1);
        tick(1);
        req = 3'b010;
        tick(2);
        req = '0;
        tick(30);
        check("cold2_width", n_cold, COLD);
        check("warm_ignored", n_warm, 0);

        // Button: short glitches never count; a long press is one warm pulse when debounced.
        tick(3);
        clear_counts();
        repeat (4) begin
            btn = 1'b0;
            tick(2);
            btn = 1'b1;
            tick(3);
        end
        check("btn_glitch_none", n_warm, 0);
        clear_counts();
        btn = 1'b0;
        tick(10);
        btn = 1'b1;
        tick(20);
`ifdef SOC_RSTSEQ_DEBOUNCE_EN
        check("btn_press_warm", n_warm, WARM);
`else
        check("btn_press_none", n_warm, 0);
`endif
        tick(5);

        // Asynchronous reset in the middle of a debug pulse.
        req = 3'b100;
        tick(1);
        req = '0;
        tick(3);
        check("debug3_on", debug, 1);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check("async_rst_debug", debug, 0);
        check("async_rst_soc", soc_rstn, 0);
        check("async_rst_state", state, 0);
        tick(2);
        rstn = 1'b1;
        tick(9);
        check("rerelease_soc_before", soc_rstn, 0);
        tick(1);
        check("rerelease_soc_at10", soc_rstn, 1);
        tick(3);

        model_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
